// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin arbitration with wormhole locking.
// Drives crossbar sel/enable and per-input dequeue grants; no flit data passes here.
module switch_allocator #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic [NUM_IN-1:0]                  req_valid,
  input  logic [NUM_IN*$clog2(NUM_OUT)-1:0]  req_dest,
  input  logic [NUM_IN-1:0]                  req_last,
  input  logic [NUM_OUT-1:0]                 out_ready,
  output logic [NUM_OUT*$clog2(NUM_IN)-1:0]  sel,
  output logic [NUM_OUT-1:0]                 enable,
  output logic [NUM_IN-1:0]                  grant
);

  localparam int IW = $clog2(NUM_IN);
  localparam int OW = $clog2(NUM_OUT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state [NUM_OUT];
  logic [IW-1:0]   owner [NUM_OUT];
  logic [IW-1:0]   ptr   [NUM_OUT];

  logic [OW-1:0]   dest  [NUM_IN];
  logic [NUM_OUT-1:0] found;
  logic [IW-1:0]   win   [NUM_OUT];

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      dest[i] = req_dest[i*OW +: OW];
    end
  end

  // Round-robin scan starting at ptr; first requester for this output wins.
  always_comb begin
    found = '0;
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      win[o] = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        logic [IW-1:0] idx;
        idx = IW'((32'(ptr[o]) + k) % NUM_IN);
        if (!found[o] && req_valid[idx] && dest[idx] == OW'(o)) begin
          found[o] = 1'b1;
          win[o]   = idx;
        end
      end
    end
  end

  always_comb begin
    enable = '0;
    grant  = '0;
    sel    = '0;
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      sel[o*IW +: IW] = owner[o];
      enable[o] = (state[o] == LOCKED) && req_valid[owner[o]] &&
                  (dest[owner[o]] == OW'(o)) && out_ready[o];
      if (enable[o]) begin
        grant[owner[o]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
        case (state[o])
          IDLE: begin
            if (found[o]) begin
              state[o] <= LOCKED;
              owner[o] <= win[o];
              ptr[o]   <= IW'((32'(win[o]) + 1) % NUM_IN);
            end
          end
          LOCKED: begin
            if (enable[o] && req_last[owner[o]]) begin
              state[o] <= IDLE;
            end
          end
          default: state[o] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator (4x4): reset, single-flit, round-robin,
// wormhole lock under backpressure, parallel outputs, reset mid-packet.
module tb_switch_allocator;

  logic       CLK;
  logic       nRST;
  logic [3:0] req_valid;
  logic [7:0] req_dest;
  logic [3:0] req_last;
  logic [3:0] out_ready;
  logic [7:0] sel;
  logic [3:0] enable;
  logic [3:0] grant;

  int errors = 0;
  int checks = 0;

  switch_allocator #(.NUM_IN(4), .NUM_OUT(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_last  (req_last),
    .out_ready (out_ready),
    .sel       (sel),
    .enable    (enable),
    .grant     (grant)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] d, input logic l);
    req_valid[i]       = v;
    req_dest[i*2 +: 2] = d;
    req_last[i]        = l;
  endtask

  // Inputs are changed at posedge+2, checked at posedge+3.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    nRST      = 1'b0;
    req_valid = 4'b1111;
    req_dest  = '0;
    req_last  = 4'b1111;
    out_ready = 4'b1111;

    // Reset holds everything quiet even with all inputs requesting.
    #12;
    chk("rst_sel",    32'(sel),    32'h00);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_grant",  32'(grant),  32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rel_no_enable", 32'(enable), 32'h0);
    tick();
    #1;
    chk("rel_enable_after_edge", 32'(enable), 32'h1);

    // Re-apply reset asynchronously to clear the binding just made.
    nRST = 1'b0;
    req_valid = '0;
    #1;
    chk("async_rst_enable", 32'(enable), 32'h0);
    chk("async_rst_sel",    32'(sel),    32'h00);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Single-flit packet: input 2 -> output 1.
    set_req(2, 1'b1, 2'd1, 1'b1);
    #1;
    chk("sf_arb_enable", 32'(enable), 32'h0);
    tick();
    #1;
    chk("sf_enable", 32'(enable),   32'b0010);
    chk("sf_sel1",   32'(sel[3:2]), 32'd2);
    chk("sf_grant",  32'(grant),    32'b0100);
    tick();
    #1;
    chk("sf_idle_enable", 32'(enable),   32'h0);
    chk("sf_idle_sel1",   32'(sel[3:2]), 32'd2);
    req_valid = '0;

    // Round-robin on output 0 among inputs 0,1,3 (single-flit packets).
    set_req(0, 1'b1, 2'd0, 1'b1);
    set_req(1, 1'b1, 2'd0, 1'b1);
    set_req(3, 1'b1, 2'd0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("rr_bubble", 32'(grant), 32'h0);
      tick();
      #1;
      chk("rr_grant", 32'(grant),    32'(4'b0001 << rr_exp[n]));
      chk("rr_sel0",  32'(sel[1:0]), 32'(rr_exp[n]));
      tick();
    end
    req_valid = '0;
    #1;

    // Wormhole: input 1 locks output 2 for 3 flits; input 0 waits.
    set_req(1, 1'b1, 2'd2, 1'b0);
    #1;
    chk("wh_arb", 32'(enable), 32'h0);
    tick();
    set_req(0, 1'b1, 2'd2, 1'b1);
    #1;
    chk("wh_f1_grant",  32'(grant),  32'b0010);
    chk("wh_f1_enable", 32'(enable), 32'b0100);
    tick();
    out_ready[2] = 1'b0;
    #1;
    chk("wh_stall_enable", 32'(enable), 32'h0);
    chk("wh_stall_grant",  32'(grant),  32'h0);
    tick();
    out_ready[2] = 1'b1;
    #1;
    chk("wh_f2_grant", 32'(grant), 32'b0010);
    tick();
    req_last[1] = 1'b1;
    #1;
    chk("wh_tail_grant", 32'(grant),    32'b0010);
    chk("wh_tail_sel2",  32'(sel[5:4]), 32'd1);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("wh_bubble", 32'(grant), 32'h0);
    tick();
    #1;
    chk("wh_next_grant",  32'(grant),    32'b0001);
    chk("wh_next_enable", 32'(enable),   32'b0100);
    chk("wh_next_sel2",   32'(sel[5:4]), 32'd0);
    tick();
    req_valid = '0;

    // Parallel: input 0 -> out 3, input 3 -> out 0.
    set_req(0, 1'b1, 2'd3, 1'b1);
    set_req(3, 1'b1, 2'd0, 1'b1);
    #1;
    chk("par_arb", 32'(enable), 32'h0);
    tick();
    #1;
    chk("par_enable", 32'(enable),   32'b1001);
    chk("par_grant",  32'(grant),    32'b1001);
    chk("par_sel3",   32'(sel[7:6]), 32'd0);
    chk("par_sel0",   32'(sel[1:0]), 32'd3);
    tick();
    req_valid = '0;

    // Reset mid-packet: input 2 sends 4-flit packet to output 1; input 3 joins.
    // After lock ptr1=3 would favour input 3; reset returns ptr to 0 so input 2 wins.
    set_req(2, 1'b1, 2'd1, 1'b0);
    #1;
    tick();
    set_req(3, 1'b1, 2'd1, 1'b1);
    #1;
    chk("rm_f1_grant", 32'(grant), 32'b0100);
    tick();
    nRST = 1'b0;
    #1;
    chk("rm_rst_enable", 32'(enable), 32'h0);
    chk("rm_rst_grant",  32'(grant),  32'h0);
    chk("rm_rst_sel",    32'(sel),    32'h00);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rm_idle_enable", 32'(enable), 32'h0);
    tick();
    #1;
    chk("rm_regrant",  32'(grant),    32'b0100);
    chk("rm_sel1",     32'(sel[3:2]), 32'd2);
    tick();
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Drives the select/enable side of the switch crossbar: decides, per output port, which input port's packet crosses the crossbar. Control only; no flit data passes through this block.
- Per-output round-robin arbitration with wormhole locking: an output stays bound to one input from head flit to tail flit.
- Sits between the input buffers (requests, dequeue grants) and the crossbar `sel`/`enable` lines. It also receives per-output downstream credit/ready.

Parameters:
- NUM_IN, 4, number of crossbar inputs (>=2)
- NUM_OUT, 4, number of crossbar outputs (>=2)

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- req_valid  input  NUM_IN  input i has a flit at its buffer head
- req_dest  input  NUM_IN x $clog2(NUM_OUT)  destination output of input i's head flit
- req_last  input  NUM_IN  input i's head flit is the packet tail
- out_ready  input  NUM_OUT  output o can accept a flit this cycle
- sel  output  NUM_OUT x $clog2(NUM_IN)  crossbar select per output
- enable  output  NUM_OUT  crossbar output enable; high = flit transfers on o this cycle
- grant  output  NUM_IN  input i's head flit is consumed this cycle (dequeue)

Behaviour:
- Per output o, registered state: state_o in {IDLE, LOCKED}, owner_o [$clog2(NUM_IN)], ptr_o [$clog2(NUM_IN)].
- Reset (async, nRST low): all state_o=IDLE, owner_o=0, ptr_o=0. Consequences: sel=0, enable=0, grant=0. Reset mid-packet drops the binding; no partial state survives.
- Requester set R_o = { i : req_valid[i] && req_dest[i]==o }.
- IDLE, R_o empty: stay IDLE.
- IDLE, R_o non-empty:
  - Winner w = first i in R_o scanning ptr_o, ptr_o+1, ... mod NUM_IN.
  - Next edge: state_o=LOCKED, owner_o=w, ptr_o=(w+1) mod NUM_IN.
  - No transfer in the arbitration cycle, so allocation latency is 1 cycle.
- LOCKED:
  - enable[o] = req_valid[owner_o] && req_dest[owner_o]==o && out_ready[o] (combinational).
  - A transfer occurs when enable[o]=1.
  - If the transfer occurs with req_last[owner_o]=1, next edge state_o=IDLE. Otherwise remain LOCKED.
  - A stall (valid low or out_ready low) holds LOCKED indefinitely.
- sel[o] = owner_o at all times. It holds the last owner while IDLE; enable[o]=0 whenever IDLE.
- grant[i] = OR over o of (enable[o] && owner_o==i). At most one bit per input, since an input has a single dest.
- Tail transfer with pending requesters in the same cycle: output goes IDLE, then arbitrates the next cycle. This is one mandatory bubble; there is no same-cycle re-arbitration.
- Single-flit packet (head=tail): 1 arbitration cycle, then transfer, then IDLE.
- Requester contract: req_dest[i] is stable from head flit until the tail is granted. The allocator does not check this.
- Outputs arbitrate independently. Different inputs targeting different outputs proceed in parallel the same cycle.
- ptr_o wraps from NUM_IN-1 to 0. Mod arithmetic is required for non-power-of-two NUM_IN.
- Combinational paths exist from req_* and out_ready to enable/grant. sel is a pure register output.

Test Plan:
- Reset check: hold nRST=0 with req_valid=4'b1111 -> sel=0, enable=0, grant=0. Release; first enable no earlier than 1 cycle after the first edge.
- Single-flit packet: input 2 sends dest=1, last=1, out_ready=1 -> cycle0 no enable. Cycle1: enable[1]=1, sel[1]=2, grant=4'b0100. Cycle2: output 1 IDLE.
- Round-robin fairness: inputs 0,1,3 all send 1-flit packets to output 0 continuously -> grant order 0,1,3,0,1,3. Each grant is separated by one arbitration bubble.
- Wormhole lock with backpressure:
  - Input 1 sends a 3-flit packet to output 2 while input 0 also requests output 2.
  - Toggle out_ready[2] 1,0,1,1 -> input 1 granted on 3 flits with enable low during the stall. Input 0 gets no grant until after input 1's tail; input 0 is allocated next.
- Parallel outputs: input 0->out 3 and input 3->out 0, both single-flit -> enable=4'b1001 in the same cycle, sel[3]=0, sel[0]=3, grant=4'b1001.
- Reset mid-packet: assert nRST after flit 1 of a 4-flit packet -> all outputs IDLE, ptr=0. After release, a pending body flit is re-arbitrated as a new request; lowest index from ptr 0 wins.
